store_size_rmw: RTL
===================

# store_size_rmw

Store-side counterpart of the load-size extractor: it takes a register value plus a store-size code and writes byte, halfword or word data into the data memory. Sub-word stores use a read-modify-write sequence, so only the selected low-order bits of the memory word change. The block sits between the datapath (B register / address ALU output) and the data memory port, and is driven by the control unit with a start/done handshake.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from presenting mem_addr with mem_wr=0 to mem_rdata being valid; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- set_store_size_control  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- store_addr  input  32  word address of the store.
- store_data  input  32  register value to store.
- mem_addr  output  32  memory address, held for the whole operation.
- mem_rdata  input  32  memory read data.
- mem_wdata  output  32  merged write data.
- mem_wr  output  1  write strobe, 1 for exactly one cycle per legal store.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid with done; 1 for an illegal size code.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: on start=1, latch store_addr, store_data and the size code, then branch:
  - size 10 goes to WRITE.
  - size 00/01 goes to READ; the latency counter loads MEM_LATENCY.
  - size 11 goes to DONE with error set.
- READ: mem_addr=latched address and mem_wr=0. The counter decrements each cycle. On the cycle the counter equals 1, mem_rdata is captured into the merge register and the FSM moves to WRITE.
- Merge rules, with zero shift (byte/half occupy the low bits, mirroring load extraction):
  - byte: mem_wdata = {rd[31:8], data[7:0]}.
  - half: mem_wdata = {rd[31:16], data[15:0]}.
  - word: mem_wdata = data.
- WRITE: mem_wr=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- error is registered; it is cleared when the next start is accepted.
- start asserted while not in IDLE is ignored and not queued. Inputs changing after acceptance have no effect.
- Reset values: state IDLE, mem_wr 0, done 0, busy 0, error 0, mem_addr 0, mem_wdata 0, counter 0.
- Reset mid-operation: immediate return to IDLE and mem_wr drops asynchronously. No partial write is ever completed after reset deassertion.

## Timing
- Start is accepted at edge 0.
- Word store: mem_wr high in cycle 1, done in cycle 2 (latency 2).
- Byte/half store: READ occupies cycles 1..MEM_LATENCY, mem_wr is high in cycle MEM_LATENCY+1, and done is high in cycle MEM_LATENCY+2.
- Illegal code: done and error are high in cycle 1. No memory access occurs.
- busy is high from cycle 1 through the done cycle inclusive.
- A new start is accepted in the cycle after done (back-to-back throughput: one op per latency+1 cycles).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- STORE_BYTE_ENABLE_EN defined:
  - Adds output mem_be[3:0].
  - Sub-word stores skip READ and go IDLE→WRITE→DONE.
  - mem_be is 0001 for byte, 0011 for half, 1111 for word; mem_wdata = {zero-fill, data bits}.
  - Every legal store then has latency 2.
  - mem_be resets to 0000 and is 0000 whenever mem_wr=0.
- Not defined:
  - No mem_be port.
  - Read-modify-write path as described above.

## Test plan
- Word store: addr=0x40, data=0xDEADBEEF, code 10 → mem_wr in cycle 1 with mem_wdata=0xDEADBEEF, done in cycle 2, no read cycles.
- Byte RMW, MEM_LATENCY=1: memory word 0x11223344, data=0xAABBCCDD, code 00 → mem_wdata=0x112233DD written in cycle 2, done in cycle 3.
- Half RMW, MEM_LATENCY=3: memory 0x11223344, data=0x0000BEEF, code 01 → mem_wdata=0x1122BEEF, mem_wr in cycle 4, done in cycle 5; a start pulse in cycle 2 is ignored.
- Illegal code 11 → done=1 and error=1 in cycle 1, mem_wr never asserted. A following legal store clears error.
- Reset low in the READ cycle of a byte store → mem_wr stays 0, all outputs at reset values, memory unchanged; after release a fresh store completes normally.
- With STORE_BYTE_ENABLE_EN: byte store, data=0x000000AB → mem_be=0001, mem_wdata=0x000000AB in cycle 1, done in cycle 2.

Source files
------------

// File: rtl/store_size_rmw.sv
// store_size_rmw: writes byte/halfword/word register data to the data memory.
// Sub-word stores read the target word, merge the low-order bits and write it
// back. Optional STORE_BYTE_ENABLE_EN build adds mem_be and drops the read
// phase, so every legal store becomes a single write.
module store_size_rmw #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  set_store_size_control,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
`ifdef STORE_BYTE_ENABLE_EN
  output logic [3:0]  mem_be,
`endif
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q, data_q, wdata_q;
  logic [1:0]  size_q;
  logic        wr_q, busy_q, done_q, err_q;
  logic [31:0] merge_d;
`ifdef STORE_BYTE_ENABLE_EN
  logic [3:0]  be_q;
`endif

  // Merge latched store data into the word read back from memory (zero shift).
  always_comb begin
    merge_d = data_q;
    case (size_q)
      SZ_BYTE: merge_d = {mem_rdata[31:8],  data_q[7:0]};
      SZ_HALF: merge_d = {mem_rdata[31:16], data_q[15:0]};
      default: merge_d = data_q;
    endcase
  end

  // Control FSM; every output is a register so nothing reaches the pins combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef STORE_BYTE_ENABLE_EN
      be_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q <= store_addr;
          data_q <= store_data;
          size_q <= set_store_size_control;
          err_q  <= 1'b0;
          busy_q <= 1'b1;
          case (set_store_size_control)
            SZ_WORD: begin
              wdata_q <= store_data;
              wr_q    <= 1'b1;
`ifdef STORE_BYTE_ENABLE_EN
              be_q    <= 4'b1111;
`endif
              state_q <= WRITE;
            end
            SZ_BYTE, SZ_HALF: begin
`ifdef STORE_BYTE_ENABLE_EN
              // Byte enables let memory do the merge, so no read is needed.
              wdata_q <= (set_store_size_control == SZ_BYTE) ?
                         {24'd0, store_data[7:0]} : {16'd0, store_data[15:0]};
              be_q    <= (set_store_size_control == SZ_BYTE) ? 4'b0001 : 4'b0011;
              wr_q    <= 1'b1;
              state_q <= WRITE;
`else
              cnt_q   <= 3'(MEM_LATENCY);
              state_q <= READ;
`endif
            end
            default: begin
              // Illegal size: report immediately, never touch memory.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          endcase
        end
        READ: begin
          // Read data is valid in the last counted cycle.
          if (cnt_q == 3'd1) begin
            wdata_q <= merge_d;
            wr_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= WRITE;
          end else begin
            cnt_q   <= cnt_q - 3'd1;
          end
        end
        WRITE: begin
          wr_q    <= 1'b0;
`ifdef STORE_BYTE_ENABLE_EN
          be_q    <= '0;
`endif
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
`ifdef STORE_BYTE_ENABLE_EN
  assign mem_be    = be_q;
`endif

endmodule
